election_phase_arbiter: RTL and testbench

ELECTION_PHASE_ARBITER -- requirements
Module: election_phase_arbiter

---
 rtl/election_phase_arbiter.sv | 150 +++++++++++++++
 tb/tb_election_phase_arbiter.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/election_phase_arbiter.sv
// Four-kiosk round-robin arbiter for the election datapath. A saturating cycle
// counter sets the phase (REG, VOTE, TALLY). The phase decides which granted operations may issue.
module election_phase_arbiter (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic [3:0]  req,
   input  logic [3:0]  req_op,
   input  logic [23:0] req_uid,
   input  logic [7:0]  req_cand,
   output logic [3:0]  grant,
   output logic [3:0]  reject,
   output logic        issue_valid,
   output logic        issue_mode,
   output logic [5:0]  issue_uid,
   output logic [1:0]  issue_cand,
   output logic [1:0]  phase,
   output logic        tally_start,
   output logic [7:0]  issued_count
);

   typedef enum logic [1:0] {
      PH_REG   = 2'b00,
      PH_VOTE  = 2'b01,
      PH_TALLY = 2'b10
   } phase_t;

   logic [7:0] cnt_reg, cnt_next;
   phase_t     phase_reg, phase_next;
   logic [1:0] ptr_reg, ptr_next;
   logic [3:0] grant_reg, grant_next;
   logic [3:0] reject_reg, reject_next;
   logic       issue_valid_reg, issue_valid_next;
   logic       issue_mode_reg, issue_mode_next;
   logic [5:0] issue_uid_reg, issue_uid_next;
   logic [1:0] issue_cand_reg, issue_cand_next;
   logic       tally_start_reg, tally_start_next;
   logic [7:0] issued_count_reg, issued_count_next;

   logic [5:0] kiosk_uid [4];
   logic [1:0] kiosk_cand [4];
   logic [3:0] eligible;
   logic [1:0] win_idx, scan_idx;
   logic       win_valid, legal;

   genvar gi;
   generate
      for (gi = 0; gi < 4; gi++) begin : g_kiosk
         assign kiosk_uid[gi]  = req_uid[6*gi +: 6];
         assign kiosk_cand[gi] = req_cand[2*gi +: 2];
      end
   endgenerate

   always_comb begin
      cnt_next          = (cnt_reg == 8'd200) ? cnt_reg : cnt_reg + 8'd1;
      phase_next        = PH_TALLY;
      win_valid         = 1'b0;
      win_idx           = ptr_reg;
      scan_idx          = ptr_reg;
      legal             = 1'b0;
      grant_next        = 4'b0000;
      reject_next       = 4'b0000;
      issue_valid_next  = 1'b0;
      issue_mode_next   = issue_mode_reg;
      issue_uid_next    = issue_uid_reg;
      issue_cand_next   = issue_cand_reg;
      ptr_next          = ptr_reg;
      issued_count_next = issued_count_reg;
      tally_start_next  = 1'b0;

      if (cnt_next < 8'd100) begin
         phase_next = PH_REG;
      end else if (cnt_next < 8'd200) begin
         phase_next = PH_VOTE;
      end

      // A kiosk whose grant is showing this cycle is about to drop req; skip it.
      eligible = req & ~grant_reg;
      for (int i = 0; i < 4; i++) begin
         scan_idx = ptr_reg + 2'(i);
         if (!win_valid && eligible[scan_idx]) begin
            win_valid = 1'b1;
            win_idx   = scan_idx;
         end
      end

      legal = ((phase_reg == PH_REG)  && !req_op[win_idx]) ||
              ((phase_reg == PH_VOTE) &&  req_op[win_idx]);

      if (win_valid) begin
         grant_next = 4'b0001 << win_idx;
         ptr_next   = win_idx + 2'd1;
         if (legal) begin
            issue_valid_next = 1'b1;
            issue_mode_next  = req_op[win_idx];
            issue_uid_next   = kiosk_uid[win_idx];
            issue_cand_next  = kiosk_cand[win_idx];
         end else begin
            reject_next = 4'b0001 << win_idx;
         end
      end

      if (phase_next != phase_reg) begin
         issued_count_next = 8'd0;
      end else if (issue_valid_next && (issued_count_reg != 8'd255)) begin
         issued_count_next = issued_count_reg + 8'd1;
      end

      // Counter saturates at 200, so this entry condition can only occur once per reset.
      tally_start_next = (phase_next == PH_TALLY) && (phase_reg != PH_TALLY);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt_reg          <= 8'd0;
         phase_reg        <= PH_REG;
         ptr_reg          <= 2'd0;
         grant_reg        <= 4'b0000;
         reject_reg       <= 4'b0000;
         issue_valid_reg  <= 1'b0;
         issue_mode_reg   <= 1'b0;
         issue_uid_reg    <= 6'd0;
         issue_cand_reg   <= 2'd0;
         tally_start_reg  <= 1'b0;
         issued_count_reg <= 8'd0;
      end else begin
         cnt_reg          <= cnt_next;
         phase_reg        <= phase_next;
         ptr_reg          <= ptr_next;
         grant_reg        <= grant_next;
         reject_reg       <= reject_next;
         issue_valid_reg  <= issue_valid_next;
         issue_mode_reg   <= issue_mode_next;
         issue_uid_reg    <= issue_uid_next;
         issue_cand_reg   <= issue_cand_next;
         tally_start_reg  <= tally_start_next;
         issued_count_reg <= issued_count_next;
      end
   end

   assign grant        = grant_reg;
   assign reject       = reject_reg;
   assign issue_valid  = issue_valid_reg;
   assign issue_mode   = issue_mode_reg;
   assign issue_uid    = issue_uid_reg;
   assign issue_cand   = issue_cand_reg;
   assign phase        = phase_reg;
   assign tally_start  = tally_start_reg;
   assign issued_count = issued_count_reg;

endmodule

// File: tb/tb_election_phase_arbiter.sv
// Directed bench for election_phase_arbiter: expected outputs are queued per driven
// cycle and compared one edge later; phase/count expectations come from a cycle model.
module tb_election_phase_arbiter;

   logic        CLK = 1'b0;
   logic        RST_N = 1'b0;
   logic [3:0]  req = '0;
   logic [3:0]  req_op = '0;
   logic [23:0] req_uid = '0;
   logic [7:0]  req_cand = '0;
   logic [3:0]  grant, reject;
   logic        issue_valid, issue_mode, tally_start;
   logic [5:0]  issue_uid;
   logic [1:0]  issue_cand, phase;
   logic [7:0]  issued_count;

   election_phase_arbiter dut (
      .CLK(CLK), .RST_N(RST_N), .req(req), .req_op(req_op), .req_uid(req_uid),
      .req_cand(req_cand), .grant(grant), .reject(reject), .issue_valid(issue_valid),
      .issue_mode(issue_mode), .issue_uid(issue_uid), .issue_cand(issue_cand),
      .phase(phase), .tally_start(tally_start), .issued_count(issued_count)
   );

   always #5 CLK = ~CLK;

   typedef struct {
      string      tag;
      logic [3:0] g, r;
      logic       iv, m, ts;
      logic [5:0] u;
      logic [1:0] c, ph;
      logic [7:0] n;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   exp_cnt = 0;
   logic       last_m = 1'b0;
   logic [5:0] last_u = '0;
   logic [1:0] last_c = '0;

   function automatic logic [1:0] ph_of(input int c);
      if (c < 100) return 2'b00;
      if (c < 200) return 2'b01;
      return 2'b10;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   task automatic set_k(input int k, input logic op, input logic [5:0] u, input logic [1:0] c);
      req_op[k]       = op;
      req_uid[6*k +: 6] = u;
      req_cand[2*k +: 2] = c;
   endtask

   // One clock: queue the expectation for the inputs currently driven, then compare.
   task automatic step(input string tag, input logic [3:0] g, input logic [3:0] r,
                       input logic iv, input logic m, input logic [5:0] u, input logic [1:0] c);
      exp_t e;
      int   nc;
      nc = (cyc < 200) ? cyc + 1 : 200;
      if (iv) begin
         last_m = m; last_u = u; last_c = c;
         if (exp_cnt < 255) exp_cnt++;
      end
      if (ph_of(nc) != ph_of(cyc)) exp_cnt = 0;
      e.tag = tag; e.g = g; e.r = r; e.iv = iv;
      e.m = last_m; e.u = last_u; e.c = last_c;
      e.ph = ph_of(nc);
      e.ts = (ph_of(nc) == 2'b10) && (ph_of(cyc) != 2'b10);
      e.n = 8'(exp_cnt);
      exp_q.push_back(e);
      cyc = nc;
      @(posedge CLK);
      #1;
      e = exp_q.pop_front();
      chk({e.tag, "_grant"}, 32'(grant), 32'(e.g));
      chk({e.tag, "_reject"}, 32'(reject), 32'(e.r));
      chk({e.tag, "_issue_valid"}, 32'(issue_valid), 32'(e.iv));
      chk({e.tag, "_issue_mode"}, 32'(issue_mode), 32'(e.m));
      chk({e.tag, "_issue_uid"}, 32'(issue_uid), 32'(e.u));
      chk({e.tag, "_issue_cand"}, 32'(issue_cand), 32'(e.c));
      chk({e.tag, "_phase"}, 32'(phase), 32'(e.ph));
      chk({e.tag, "_tally_start"}, 32'(tally_start), 32'(e.ts));
      chk({e.tag, "_issued_count"}, 32'(issued_count), 32'(e.n));
      if (e.tag != "idle")
         $display("txn %-14s cyc=%0d grant=%b reject=%b issue_valid=%b uid=%0d cand=%0d phase=%0d count=%0d",
                  e.tag, cyc, grant, reject, issue_valid, issue_uid, issue_cand, phase, issued_count);
   endtask

   task automatic idle_to(input int target);
      while (cyc < target) step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, 2'd0);
   endtask

   task automatic idle_n(input int n);
      for (int i = 0; i < n; i++) step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, 2'd0);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_grant"}, 32'(grant), 32'd0);
      chk({tag, "_reject"}, 32'(reject), 32'd0);
      chk({tag, "_issue_valid"}, 32'(issue_valid), 32'd0);
      chk({tag, "_issue_mode"}, 32'(issue_mode), 32'd0);
      chk({tag, "_issue_uid"}, 32'(issue_uid), 32'd0);
      chk({tag, "_issue_cand"}, 32'(issue_cand), 32'd0);
      chk({tag, "_phase"}, 32'(phase), 32'd0);
      chk({tag, "_tally_start"}, 32'(tally_start), 32'd0);
      chk({tag, "_issued_count"}, 32'(issued_count), 32'd0);
      $display("txn %-14s reset outputs grant=%b issue_valid=%b phase=%0d count=%0d",
               tag, grant, issue_valid, phase, issued_count);
   endtask

   task automatic model_reset();
      cyc = 0; exp_cnt = 0; last_m = 1'b0; last_u = '0; last_c = '0;
      exp_q.delete();
   endtask

   initial begin
      repeat (2) @(posedge CLK);
      #1;
      check_reset("rst_init");
      RST_N = 1'b1;
      model_reset();

      // Round robin from reset with all four kiosks registering
      set_k(0, 1'b0, 6'd11, 2'd0); set_k(1, 1'b0, 6'd12, 2'd1);
      set_k(2, 1'b0, 6'd13, 2'd2); set_k(3, 1'b0, 6'd14, 2'd3);
      req = 4'b1111;
      step("rr_k0", 4'b0001, 4'b0000, 1'b1, 1'b0, 6'd11, 2'd0); req[0] = 1'b0;
      step("rr_k1", 4'b0010, 4'b0000, 1'b1, 1'b0, 6'd12, 2'd1); req[1] = 1'b0;
      step("rr_k2", 4'b0100, 4'b0000, 1'b1, 1'b0, 6'd13, 2'd2); req[2] = 1'b0;
      step("rr_k3", 4'b1000, 4'b0000, 1'b1, 1'b0, 6'd14, 2'd3); req[3] = 1'b0;

      // Just-granted kiosk 0 is masked, so kiosk 3 wins, then kiosk 0
      set_k(0, 1'b0, 6'd21, 2'd1);
      req = 4'b0001;
      step("k0_first", 4'b0001, 4'b0000, 1'b1, 1'b0, 6'd21, 2'd1);
      set_k(0, 1'b0, 6'd23, 2'd3); set_k(3, 1'b0, 6'd22, 2'd2);
      req = 4'b1001;
      step("k3_over_k0", 4'b1000, 4'b0000, 1'b1, 1'b0, 6'd22, 2'd2); req[3] = 1'b0;
      step("k0_next", 4'b0001, 4'b0000, 1'b1, 1'b0, 6'd23, 2'd3); req = 4'b0000;

      // Vote during REG is rejected
      idle_to(50);
      set_k(2, 1'b1, 6'd37, 2'b11);
      req = 4'b0100;
      step("vote_in_reg", 4'b0100, 4'b0100, 1'b0, 1'b0, 6'd0, 2'd0); req = 4'b0000;
      step("idle", 4'b0000, 4'b0000, 1'b0, 1'b0, 6'd0, 2'd0);

      // Register sampled at counter 99 is legal; the phase change clears the count
      idle_to(99);
      set_k(0, 1'b0, 6'd5, 2'd1);
      req = 4'b0001;
      step("reg_at_99", 4'b0001, 4'b0000, 1'b1, 1'b0, 6'd5, 2'd1); req = 4'b0000;

      idle_to(120);
      set_k(1, 1'b1, 6'd20, 2'b10);
      req = 4'b0010;
      step("vote_at_120", 4'b0010, 4'b0000, 1'b1, 1'b1, 6'd20, 2'b10); req = 4'b0000;
      set_k(3, 1'b0, 6'd30, 2'd1);
      req = 4'b1000;
      step("reg_in_vote", 4'b1000, 4'b1000, 1'b0, 1'b0, 6'd0, 2'd0); req = 4'b0000;

      // Vote sampled at counter 199 still issues; TALLY entry clears count and pulses tally_start
      idle_to(199);
      set_k(2, 1'b1, 6'd40, 2'd0);
      req = 4'b0100;
      step("vote_at_199", 4'b0100, 4'b0000, 1'b1, 1'b1, 6'd40, 2'd0); req = 4'b0000;
      idle_n(3);
      set_k(0, 1'b0, 6'd1, 2'd0);
      req = 4'b0001;
      step("reg_in_tally", 4'b0001, 4'b0001, 1'b0, 1'b0, 6'd0, 2'd0);
      set_k(3, 1'b1, 6'd2, 2'd1);
      req = 4'b1000;
      step("vote_in_tally", 4'b1000, 4'b1000, 1'b0, 1'b0, 6'd0, 2'd0); req = 4'b0000;
      idle_n(2);

      RST_N = 1'b0;
      #1;
      check_reset("rst_tally");
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      model_reset();

      // Reset mid-VOTE with a grant in flight and another request pending
      idle_to(149);
      set_k(1, 1'b1, 6'd9, 2'd1);
      req = 4'b0010;
      step("vote_at_149", 4'b0010, 4'b0000, 1'b1, 1'b1, 6'd9, 2'd1);
      set_k(2, 1'b1, 6'd10, 2'd2);
      req = 4'b0100;
      RST_N = 1'b0;
      #1;
      check_reset("rst_mid");
      @(posedge CLK);
      #1;
      req = 4'b0000;
      RST_N = 1'b1;
      model_reset();
      idle_to(101);

      // Pointer returned to kiosk 0 by reset
      set_k(0, 1'b1, 6'd50, 2'd0); set_k(1, 1'b1, 6'd51, 2'd1);
      set_k(2, 1'b1, 6'd52, 2'd2); set_k(3, 1'b1, 6'd53, 2'd3);
      req = 4'b1111;
      step("ptr_after_rst", 4'b0001, 4'b0000, 1'b1, 1'b1, 6'd50, 2'd0); req[0] = 1'b0;
      step("ptr_next_k1", 4'b0010, 4'b0000, 1'b1, 1'b1, 6'd51, 2'd1);
      req = 4'b0000;
      idle_n(2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
